// File: rtl/dbg_bridge_pkg.sv
// Shared encodings for the debug UART bridge host.
// Holds the command kinds, control nibbles, protocol bytes, error codes,
// the host FSM state type and a helper that maps a command kind to its
// header control nibble.
package dbg_bridge_pkg;

  localparam logic [1:0] KIND_SYNC = 2'd0;
  localparam logic [1:0] KIND_WR   = 2'd1;
  localparam logic [1:0] KIND_RD   = 2'd2;
  localparam logic [1:0] KIND_TR   = 2'd3;

  localparam logic [3:0] CTRL_WR = 4'hC;
  localparam logic [3:0] CTRL_RD = 4'h8;
  localparam logic [3:0] CTRL_TR = 4'hD;

  localparam logic [7:0] BYTE_SYNC = 8'h55;
  localparam logic [7:0] BYTE_ACK  = 8'h00;
  localparam logic [7:0] BYTE_ATT  = 8'hAA;
  localparam logic [7:0] BYTE_ADC  = 8'h77;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_TMO = 2'd1;
  localparam logic [1:0] ERR_BAD = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC_TX, ST_SYNC_WAIT, ST_HDR_TX, ST_WR_DATA, ST_WR_ACK,
    ST_RD_ACK, ST_RD_DATA, ST_ADC_TS, ST_ADC_DATA, ST_DONE
  } state_t;

  function automatic logic [3:0] ctrl_nibble(input logic [1:0] kind);
    case (kind)
      KIND_WR: ctrl_nibble = CTRL_WR;
      KIND_RD: ctrl_nibble = CTRL_RD;
      default: ctrl_nibble = CTRL_TR;
    endcase
  endfunction

endpackage

// File: rtl/dbg_bridge_tmo.sv
// Reply timeout counter, counted in 1 kHz ticks.
// Ports: i_clk/i_rst (async, active-high), i_en clock enable, i_tick 1 kHz
// strobe, i_load reloads the counter, o_expired high while the count is 0.
// A LOAD of 0 disables expiry altogether.
module dbg_bridge_tmo #(
  parameter int unsigned LOAD = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_load,
  output logic o_expired
);

  localparam logic [9:0] LOAD_V = 10'(LOAD);

  logic [9:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_load)
        r_cnt <= LOAD_V;
      else if (i_tick && (r_cnt != '0))
        r_cnt <= r_cnt - 10'd1;
    end
  end

  // The host only looks at this in receive states, which are always entered
  // with a reload, so the zero count after reset is harmless.
  assign o_expired = (LOAD_V != '0) && (r_cnt == '0);

endmodule

// File: rtl/dbg_bridge_uart_host.sv
// Host-side initiator for the debug UART bridge.
// Local side: ACmd* command handshake, AWr* write payload, ARd* read/ADC
// payload, ADone/AErr completion, AAtt*/AAdc* unsolicited frame events.
// Codec side: ATx* byte stream out (valid/ready), ARx* byte strobe in.
// AClkHEn freezes all state; AResetH is asynchronous, active-high.
module dbg_bridge_uart_host
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned CTimeoutMs = 100
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic        ASync1K,
  input  logic        ACmdReq,
  input  logic [1:0]  ACmdKind,
  input  logic [11:0] ACmdAddr,
  input  logic [15:0] ACmdLen,
  output logic        ACmdAck,
  input  logic [7:0]  AWrData,
  input  logic        AWrValid,
  output logic        AWrReady,
  output logic [7:0]  ARdData,
  output logic        ARdValid,
  output logic        ARdAdc,
  output logic        ADone,
  output logic [1:0]  AErr,
  output logic        AAttEvt,
  output logic [39:0] AAdcTs,
  output logic        AAdcEvt,
  input  logic [15:0] AAdcBytes,
  output logic        ABusy,
  output logic [7:0]  ATxData,
  output logic        ATxValid,
  input  logic        ATxReady,
  input  logic [7:0]  ARxData,
  input  logic        ARxValid
);

  state_t      r_state, w_state;
  logic        r_tx_valid, w_tx_valid;
  logic [7:0]  r_tx_data, w_tx_data;
  logic [1:0]  r_idx, w_idx;
  logic [1:0]  r_kind, w_kind;
  logic [11:0] r_addr, w_addr;
  logic [15:0] r_len, w_len;
  logic [15:0] r_cnt, w_cnt;
  logic [39:0] r_ts, w_ts;
  logic [2:0]  r_ts_idx, w_ts_idx;
  logic [1:0]  r_err, w_err;
  logic [7:0]  r_rd_data, w_rd_data;
  logic        r_rd_valid, w_rd_valid;
  logic        r_rd_adc, w_rd_adc;
  logic        r_att, w_att;
  logic        r_adc_evt, w_adc_evt;
  logic        w_tmo_load, w_tmo_exp, w_wr, w_tx_fire;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [1:0] kind,
                                          input logic [11:0] addr, input logic [15:0] len);
    case (idx)
      2'd0:    hdr_byte = {ctrl_nibble(kind), addr[11:8]};
      2'd1:    hdr_byte = addr[7:0];
      2'd2:    hdr_byte = len[7:0];
      default: hdr_byte = len[15:8];
    endcase
  endfunction

  dbg_bridge_tmo #(.LOAD(CTimeoutMs)) u_tmo (
    .i_clk     (AClkH),
    .i_rst     (AResetH),
    .i_en      (AClkHEn),
    .i_tick    (ASync1K),
    .i_load    (w_tmo_load),
    .o_expired (w_tmo_exp)
  );

  // Write payload bypasses the TX register so a byte costs no extra cycle.
  assign w_wr      = (r_state == ST_WR_DATA);
  assign ATxValid  = w_wr ? AWrValid : r_tx_valid;
  assign ATxData   = w_wr ? AWrData : r_tx_data;
  assign AWrReady  = w_wr & AWrValid & ATxReady;
  assign w_tx_fire = ATxValid & ATxReady;
  // A received byte in Idle wins over a command in the same cycle.
  assign ACmdAck   = AClkHEn & ACmdReq & ~ARxValid & (r_state == ST_IDLE);
  assign ADone     = (r_state == ST_DONE);
  assign ABusy     = (r_state != ST_IDLE);
  assign AErr      = r_err;
  assign ARdData   = r_rd_data;
  assign ARdValid  = r_rd_valid;
  assign ARdAdc    = r_rd_adc;
  assign AAttEvt   = r_att;
  assign AAdcEvt   = r_adc_evt;
  assign AAdcTs    = r_ts;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_state    <= ST_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_idx      <= '0;
      r_kind     <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_ts       <= '0;
      r_ts_idx   <= '0;
      r_err      <= ERR_OK;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_adc   <= 1'b0;
      r_att      <= 1'b0;
      r_adc_evt  <= 1'b0;
    end else if (AClkHEn) begin
      r_state    <= w_state;
      r_tx_valid <= w_tx_valid;
      r_tx_data  <= w_tx_data;
      r_idx      <= w_idx;
      r_kind     <= w_kind;
      r_addr     <= w_addr;
      r_len      <= w_len;
      r_cnt      <= w_cnt;
      r_ts       <= w_ts;
      r_ts_idx   <= w_ts_idx;
      r_err      <= w_err;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_rd_adc   <= w_rd_adc;
      r_att      <= w_att;
      r_adc_evt  <= w_adc_evt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tx_valid = r_tx_valid;
    w_tx_data  = r_tx_data;
    w_idx      = r_idx;
    w_kind     = r_kind;
    w_addr     = r_addr;
    w_len      = r_len;
    w_cnt      = r_cnt;
    w_ts       = r_ts;
    w_ts_idx   = r_ts_idx;
    w_err      = r_err;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_rd_adc   = 1'b0;
    w_att      = 1'b0;
    w_adc_evt  = 1'b0;
    w_tmo_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ARxValid) begin
          if (ARxData == BYTE_ATT) begin
            w_att = 1'b1;
          end else if (ARxData == BYTE_ADC) begin
            w_state    = ST_ADC_TS;
            w_ts_idx   = '0;
            w_tmo_load = 1'b1;
          end
        end else if (ACmdReq) begin
          w_kind     = ACmdKind;
          w_addr     = ACmdAddr;
          w_len      = ACmdLen;
          w_cnt      = ACmdLen;
          w_err      = ERR_OK;
          w_idx      = '0;
          w_tx_valid = 1'b1;
          if (ACmdKind == KIND_SYNC) begin
            w_state   = ST_SYNC_TX;
            w_tx_data = BYTE_SYNC;
          end else begin
            w_state   = ST_HDR_TX;
            w_tx_data = hdr_byte(2'd0, ACmdKind, ACmdAddr, ACmdLen);
          end
        end
      end
      ST_SYNC_TX: begin
        if (w_tx_fire) begin
          w_tx_valid = 1'b0;
          w_state    = ST_SYNC_WAIT;
          w_tmo_load = 1'b1;
        end
      end
      ST_SYNC_WAIT: begin
        if (ARxValid) begin
          if (ARxData != BYTE_SYNC) w_err = ERR_BAD;
          w_state = ST_DONE;
        end else if (w_tmo_exp) begin
          w_err   = ERR_TMO;
          w_state = ST_DONE;
        end
      end
      ST_HDR_TX: begin
        if (w_tx_fire) begin
          w_idx = r_idx + 2'd1;
          if (r_idx != 2'd3) begin
            w_tx_data = hdr_byte(r_idx + 2'd1, r_kind, r_addr, r_len);
          end else begin
            w_tx_valid = 1'b0;
            if (r_kind == KIND_RD) begin
              w_state    = ST_RD_ACK;
              w_tmo_load = 1'b1;
            end else if (r_len != '0) begin
              w_state = ST_WR_DATA;
            end else if (r_kind == KIND_WR) begin
              w_state    = ST_WR_ACK;
              w_tmo_load = 1'b1;
            end else begin
              w_state = ST_DONE;
            end
          end
        end
      end
      ST_WR_DATA: begin
        if (w_tx_fire) begin
          w_cnt = r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            if (r_kind == KIND_WR) begin
              w_state    = ST_WR_ACK;
              w_tmo_load = 1'b1;
            end else begin
              w_state = ST_DONE;
            end
          end
        end
      end
      ST_WR_ACK, ST_RD_ACK: begin
        if (ARxValid) begin
          if (ARxData != BYTE_ACK) begin
            w_err   = ERR_BAD;
            w_state = ST_DONE;
          end else if ((r_state == ST_RD_ACK) && (r_len != '0)) begin
            w_state    = ST_RD_DATA;
            w_tmo_load = 1'b1;
          end else begin
            w_state = ST_DONE;
          end
        end else if (w_tmo_exp) begin
          w_err   = ERR_TMO;
          w_state = ST_DONE;
        end
      end
      ST_RD_DATA: begin
        if (ARxValid) begin
          w_rd_valid = 1'b1;
          w_rd_data  = ARxData;
          w_cnt      = r_cnt - 16'd1;
          w_tmo_load = 1'b1;
          if (r_cnt == 16'd1) w_state = ST_DONE;
        end else if (w_tmo_exp) begin
          w_err   = ERR_TMO;
          w_state = ST_DONE;
        end
      end
      ST_ADC_TS: begin
        if (ARxValid) begin
          w_tmo_load = 1'b1;
          w_ts_idx   = r_ts_idx + 3'd1;
          // Timestamp is 40 bits; the top three bytes on the wire are padding.
          case (r_ts_idx)
            3'd0:    w_ts[7:0]   = ARxData;
            3'd1:    w_ts[15:8]  = ARxData;
            3'd2:    w_ts[23:16] = ARxData;
            3'd3:    w_ts[31:24] = ARxData;
            3'd4:    w_ts[39:32] = ARxData;
            default: ;
          endcase
          if (r_ts_idx == 3'd7) begin
            w_adc_evt = 1'b1;
            w_cnt     = AAdcBytes;
            w_state   = (AAdcBytes == '0) ? ST_IDLE : ST_ADC_DATA;
          end
        end else if (w_tmo_exp) begin
          w_state = ST_IDLE;
        end
      end
      ST_ADC_DATA: begin
        if (ARxValid) begin
          w_rd_valid = 1'b1;
          w_rd_adc   = 1'b1;
          w_rd_data  = ARxData;
          w_cnt      = r_cnt - 16'd1;
          w_tmo_load = 1'b1;
          if (r_cnt == 16'd1) w_state = ST_IDLE;
        end else if (w_tmo_exp) begin
          w_state = ST_IDLE;
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_bridge_uart_host.sv
// Scoreboard bench for dbg_bridge_uart_host: directed commands and replies,
// expected TX bytes / read bytes / completions / ADC timestamps queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_dbg_bridge_uart_host;

  logic        AClkH = 1'b0;
  logic        AResetH, AClkHEn, ASync1K, ACmdReq;
  logic [1:0]  ACmdKind;
  logic [11:0] ACmdAddr;
  logic [15:0] ACmdLen;
  logic        ACmdAck;
  logic [7:0]  AWrData;
  logic        AWrValid, AWrReady;
  logic [7:0]  ARdData;
  logic        ARdValid, ARdAdc, ADone;
  logic [1:0]  AErr;
  logic        AAttEvt;
  logic [39:0] AAdcTs;
  logic        AAdcEvt;
  logic [15:0] AAdcBytes;
  logic        ABusy;
  logic [7:0]  ATxData;
  logic        ATxValid, ATxReady;
  logic [7:0]  ARxData;
  logic        ARxValid;

  logic [7:0]  tx_q[$];
  logic [7:0]  wr_q[$];
  logic [8:0]  rd_q[$];
  logic [1:0]  done_q[$];
  logic [39:0] adc_q[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, att_cnt = 0;
  logic stall_en;

  dbg_bridge_uart_host #(.CTimeoutMs(3)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .ASync1K(ASync1K),
    .ACmdReq(ACmdReq), .ACmdKind(ACmdKind), .ACmdAddr(ACmdAddr), .ACmdLen(ACmdLen),
    .ACmdAck(ACmdAck), .AWrData(AWrData), .AWrValid(AWrValid), .AWrReady(AWrReady),
    .ARdData(ARdData), .ARdValid(ARdValid), .ARdAdc(ARdAdc), .ADone(ADone),
    .AErr(AErr), .AAttEvt(AAttEvt), .AAdcTs(AAdcTs), .AAdcEvt(AAdcEvt),
    .AAdcBytes(AAdcBytes), .ABusy(ABusy), .ATxData(ATxData), .ATxValid(ATxValid),
    .ATxReady(ATxReady), .ARxData(ARxData), .ARxValid(ARxValid)
  );

  always #5 AClkH = ~AClkH;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin : monitor
    logic       hold_pend;
    logic [7:0] hold_data;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge AClkH);
      if (AResetH) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) chk_eq("tx_hold", {ATxValid, ATxData}, {1'b1, hold_data});
        hold_pend = ATxValid & ~ATxReady;
        hold_data = ATxData;
        if (ATxValid && ATxReady) begin
          chk_eq("tx_expected", 64'(tx_q.size() != 0), 1);
          if (tx_q.size() != 0) chk_eq("tx_byte", ATxData, tx_q.pop_front());
        end
        if (ARdValid) begin
          chk_eq("rd_expected", 64'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) chk_eq("rd_byte", {ARdAdc, ARdData}, rd_q.pop_front());
        end
        if (ADone) begin
          done_cnt++;
          chk_eq("done_expected", 64'(done_q.size() != 0), 1);
          if (done_q.size() != 0) chk_eq("done_err", AErr, done_q.pop_front());
        end
        if (AAttEvt) att_cnt++;
        if (AAdcEvt) begin
          chk_eq("adc_expected", 64'(adc_q.size() != 0), 1);
          if (adc_q.size() != 0) chk_eq("adc_ts", AAdcTs, adc_q.pop_front());
        end
      end
    end
  end

  // Write payload source: holds each byte until AWrReady takes it.
  initial begin : wr_driver
    logic wr_fire;
    AWrValid = 1'b0;
    AWrData  = '0;
    forever begin
      @(negedge AClkH);
      wr_fire = AWrReady;
      @(posedge AClkH);
      #1;
      if (wr_fire && (wr_q.size() != 0)) void'(wr_q.pop_front());
      AWrValid = (wr_q.size() != 0);
      AWrData  = (wr_q.size() != 0) ? wr_q[0] : 8'h00;
    end
  end

  initial begin : ready_driver
    ATxReady = 1'b1;
    forever begin
      @(posedge AClkH);
      #1;
      ATxReady = stall_en ? ~ATxReady : 1'b1;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic [1:0] k, input logic [11:0] a, input logic [15:0] l);
    @(posedge AClkH); #1;
    ACmdReq = 1'b1; ACmdKind = k; ACmdAddr = a; ACmdLen = l;
    @(negedge AClkH);
    chk_eq("cmd_ack", ACmdAck, 1);
    @(posedge AClkH); #1;
    ACmdReq = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge AClkH); #1;
    ARxData = b; ARxValid = 1'b1;
    @(posedge AClkH); #1;
    ARxValid = 1'b0;
  endtask

  task automatic tick1k();
    @(posedge AClkH); #1;
    ASync1K = 1'b1;
    @(posedge AClkH); #1;
    ASync1K = 1'b0;
    repeat (2) @(posedge AClkH);
  endtask

  task automatic wait_tx_drained(input int budget);
    int n = 0;
    while ((tx_q.size() != 0) && (n < budget)) begin
      @(posedge AClkH);
      n++;
    end
    chk_eq("tx_drain_in_time", tx_q.size(), 0);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      @(posedge AClkH);
      n++;
    end
    chk_eq("done_in_time", done_cnt, d0 + 1);
    #1;
    chk_eq("busy_after_done", ABusy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk_eq({tag, "_strobes"},
           {ACmdAck, AWrReady, ARdValid, ARdAdc, ADone, AAttEvt, AAdcEvt, ATxValid}, 0);
    chk_eq({tag, "_err"}, AErr, 0);
    chk_eq({tag, "_adcts"}, AAdcTs, 0);
    chk_eq({tag, "_txdata"}, ATxData, 0);
    chk_eq({tag, "_rddata"}, ARdData, 0);
    chk_eq({tag, "_busy"}, ABusy, 0);
  endtask

  initial begin : main
    int d0;
    int a0;
    AResetH = 1'b1; AClkHEn = 1'b1; ASync1K = 1'b0; ACmdReq = 1'b0;
    ACmdKind = '0; ACmdAddr = '0; ACmdLen = '0; AAdcBytes = '0;
    ARxData = '0; ARxValid = 1'b0; stall_en = 1'b0;
    repeat (2) @(posedge AClkH);
    #1;
    check_reset("rst0");
    AResetH = 1'b0;

    // Sync: 0x55 out, 0x55 back after 5 cycles.
    tx_q.push_back(8'h55); done_q.push_back(2'd0); d0 = done_cnt;
    issue(2'd0, 12'h000, 16'd0);
    repeat (5) @(posedge AClkH);
    send_rx(8'h55);
    wait_done(d0, 50);

    // Write with a stalling codec.
    stall_en = 1'b1;
    foreach (tx_q[i]) tx_q.delete(i);
    tx_q = '{8'hC1, 8'h23, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    wr_q = '{8'h11, 8'h22, 8'h33};
    done_q.push_back(2'd0); d0 = done_cnt;
    issue(2'd1, 12'h123, 16'd3);
    wait_tx_drained(100);
    stall_en = 1'b0;
    send_rx(8'h00);
    wait_done(d0, 50);

    // Read two bytes.
    tx_q = '{8'h87, 8'h00, 8'h02, 8'h00};
    rd_q = '{{1'b0, 8'hAB}, {1'b0, 8'hCD}};
    done_q.push_back(2'd0); d0 = done_cnt;
    issue(2'd2, 12'h700, 16'd2);
    wait_tx_drained(50);
    send_rx(8'h00); send_rx(8'hAB); send_rx(8'hCD);
    wait_done(d0, 50);
    chk_eq("rd_all_seen", rd_q.size(), 0);

    // Transact: no ack byte, completes after the payload.
    tx_q = '{8'hD0, 8'h0F, 8'h01, 8'h00, 8'h42};
    wr_q = '{8'h42};
    done_q.push_back(2'd0); d0 = done_cnt;
    issue(2'd3, 12'h00F, 16'd1);
    wait_tx_drained(50);
    wait_done(d0, 50);

    // Attention byte plus a stray byte that must be dropped.
    a0 = att_cnt;
    send_rx(8'hAA);
    send_rx(8'h3C);
    repeat (3) @(posedge AClkH);
    #1;
    chk_eq("att_count", att_cnt, a0 + 1);
    chk_eq("att_not_busy", ABusy, 0);

    // ADC frame: timestamp then 4 payload bytes.
    AAdcBytes = 16'd4;
    d0 = done_cnt;
    adc_q.push_back(40'h05_0403_0201);
    rd_q = '{{1'b1, 8'h10}, {1'b1, 8'h20}, {1'b1, 8'h30}, {1'b1, 8'h40}};
    send_rx(8'h77);
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    send_rx(8'h05); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
    send_rx(8'h10); send_rx(8'h20); send_rx(8'h30); send_rx(8'h40);
    repeat (2) @(posedge AClkH);
    #1;
    chk_eq("adc_all_seen", {adc_q.size(), rd_q.size()}, 0);
    chk_eq("adc_no_done", done_cnt, d0);
    chk_eq("adc_idle", ABusy, 0);

    // Read with no reply: timeout after the third 1 kHz strobe.
    tx_q = '{8'h82, 8'h10, 8'h01, 8'h00};
    done_q.push_back(2'd1); d0 = done_cnt;
    issue(2'd2, 12'h210, 16'd1);
    wait_tx_drained(50);
    tick1k();
    tick1k();
    chk_eq("tmo_not_early", done_cnt, d0);
    tick1k();
    wait_done(d0, 20);

    // Write acked with a bad byte.
    tx_q = '{8'hC0, 8'h45, 8'h01, 8'h00, 8'h99};
    wr_q = '{8'h99};
    done_q.push_back(2'd2); d0 = done_cnt;
    issue(2'd1, 12'h045, 16'd1);
    wait_tx_drained(50);
    send_rx(8'h5A);
    wait_done(d0, 50);

    // Reset in the middle of a header.
    tx_q = '{8'hC3, 8'hF0, 8'h02, 8'h00, 8'hE1, 8'hE2};
    wr_q = '{8'hE1, 8'hE2};
    d0 = done_cnt;
    issue(2'd1, 12'h3F0, 16'd2);
    @(posedge AClkH);
    #3;
    AResetH = 1'b1;
    #1;
    check_reset("rst_mid");
    tx_q.delete();
    wr_q.delete();
    repeat (2) @(posedge AClkH);
    #1;
    AResetH = 1'b0;
    chk_eq("rst_no_done", done_cnt, d0);

    // Clean read after the reset.
    tx_q = '{8'h8A, 8'hBC, 8'h01, 8'h00};
    rd_q = '{{1'b0, 8'h5E}};
    done_q.push_back(2'd0); d0 = done_cnt;
    issue(2'd2, 12'hABC, 16'd1);
    wait_tx_drained(50);
    send_rx(8'h00); send_rx(8'h5E);
    wait_done(d0, 50);

    repeat (3) @(posedge AClkH);
    chk_eq("queues_empty", tx_q.size() + rd_q.size() + done_q.size() + adc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
